mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, RAM byte-address width (RAM size 2^ADDR_WIDTH bytes).
REQ-002 Parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, >= 4).
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset rst, synchronous, active-high.
REQ-005 en  input  1  bus-cycle enable; bus request ignored when low.
REQ-006 mem_a  input  32  byte address from requester.
REQ-007 mem_wr  input  1  1 = write, 0 = read.
REQ-008 mem_dout  input  8  write data from requester.
REQ-009 mem_din  output  8  registered read data to requester.
REQ-010 io_buffer_full  output  1  output-FIFO almost-full back-pressure to requester.
REQ-011 rx_valid / rx_data  input  1 / 8  host input byte available / value.
REQ-012 rx_pop  output  1  one-cycle pulse consuming current rx byte.
REQ-013 tx_valid / tx_data  output  1 / 8  output FIFO head valid / value.
REQ-014 tx_ready  input  1  downstream accepts tx_data this cycle.
REQ-015 halt  output  1  sticky program-end flag.
REQ-016 overflow  output  1  sticky FIFO-overflow flag.

Function
REQ-017 Decode: mem_a[17:16] == 2'b11 selects IO space; otherwise RAM at mem_a[ADDR_WIDTH-1:0].
REQ-018 Every bus cycle with en=1 is one independent byte access; no request handshake, no multi-cycle state.
REQ-019 RAM write (en, mem_wr, RAM space): byte stored at posedge; mem_din holds its previous value.
REQ-020 RAM read (en, !mem_wr, RAM space): mem_din <= ram[addr] at the sampling posedge; data is visible to the requester's next posedge (1-cycle latency; back-to-back reads at consecutive addresses stream one byte per cycle).
REQ-021 Read of an address written in the same cycle returns the old byte (read-before-write).
REQ-022 IO write 0x30000: push mem_dout into output FIFO; if FIFO full (count == FIFO_DEPTH) byte dropped and overflow set.
REQ-023 IO write 0x30004: halt set to 1; stays 1 until reset.
REQ-024 IO read 0x30000: mem_din <= rx_data and rx_pop pulses 1 cycle if rx_valid; mem_din <= 0, no pop, if !rx_valid.
REQ-025 IO read 0x30004: mem_din <= {6'b0, overflow, io_buffer_full}.
REQ-026 Other IO addresses: writes ignored, reads return 0.
REQ-027 tx_valid = (count != 0); tx_data = FIFO head, combinational from storage; pop when tx_valid && tx_ready.
REQ-028 Push and pop in same cycle: both performed, count unchanged; push to full FIFO with simultaneous pop is accepted (no overflow).
REQ-029 Read/write pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-030 io_buffer_full = (count >= FIFO_DEPTH-2), registered; margin covers requester pipeline delay.
REQ-031 en=0: no RAM/IO access, mem_din and rx_pop (0) held; FIFO drain to tx side continues.

Reset
REQ-032 On rst: mem_din=0, count=0, pointers=0, tx_valid=0, io_buffer_full=0, rx_pop=0, halt=0, overflow=0.
REQ-033 rst has priority over en and all bus activity; a write in the reset cycle is not performed; RAM contents not reset.
REQ-034 Reset mid-drain: FIFO contents discarded, tx_valid=0 the cycle after rst.

Verification
REQ-035 Write 0x12,0x34,0x56,0x78 to 0x100..0x103, then 4 consecutive reads -> mem_din = 0x12,0x34,0x56,0x78 one cycle after each read address.
REQ-036 tx_ready=0, write 0x41 to 0x30000 eight times (depth 8) -> io_buffer_full=1 after 6th push; 9th write sets overflow=1, count stays 8; read 0x30004 -> 0x03.
REQ-037 tx_ready=1 while writing 'A','B','C' to 0x30000 on consecutive cycles -> tx_data sequence 0x41,0x42,0x43, FIFO empty afterwards.
REQ-038 rx_valid=1, rx_data=0x5A, read 0x30000 -> mem_din=0x5A, rx_pop one-cycle pulse; with rx_valid=0 -> mem_din=0x00, no pulse.
REQ-039 Write 0x30004 -> halt=1 next cycle; assert rst with 3 bytes in FIFO -> halt=0, tx_valid=0, overflow=0, RAM byte at 0x100 still 0x12.
REQ-040 en=0 with mem_wr=1 at 0x100 data 0xFF -> subsequent read with en=1 returns 0x12.

Source files
------------

// File: rtl/mem_responder.sv
// Byte-wide memory/IO responder: RAM plus memory-mapped host IO (rx byte in,
// tx FIFO out, halt/status registers) behind a single-cycle bus.
module mem_responder #(
   parameter int ADDR_WIDTH = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [31:0] mem_a,
   input  logic       mem_wr,
   input  logic [7:0] mem_dout,
   output logic [7:0] mem_din,
   output logic       io_buffer_full,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       rx_pop,
   output logic       tx_valid,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       halt,
   output logic       overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] ALMOST_C = CW'(FIFO_DEPTH - 2);

   logic [7:0] ram [2**ADDR_WIDTH];
   logic [7:0] ram_rd_q;
   logic [7:0] fifo_mem [FIFO_DEPTH];

   logic [7:0]    io_rd_q, io_rd_d;
   logic          rd_sel_q, rd_sel_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          halt_q, halt_d;
   logic          ovf_q, ovf_d;
   logic          full_q, full_d;

   logic [ADDR_WIDTH-1:0] ram_addr;
   logic io_sel, io_data_reg, io_stat_reg;
   logic bus_wr, bus_rd, ram_we, ram_re;
   logic push_req, push_ok, pop, halt_set, rx_rd;
   logic unused_bits;

   assign ram_addr    = mem_a[ADDR_WIDTH-1:0];
   assign io_sel      = (mem_a[17:16] == 2'b11);
   assign io_data_reg = (mem_a[15:0] == 16'h0000);
   assign io_stat_reg = (mem_a[15:0] == 16'h0004);
   assign unused_bits = ^mem_a[31:18];

   // Reset outranks every bus action, including RAM and FIFO writes.
   assign bus_wr   = !rst && en && mem_wr;
   assign bus_rd   = !rst && en && !mem_wr;
   assign ram_we   = bus_wr && !io_sel;
   assign ram_re   = bus_rd && !io_sel;
   assign push_req = bus_wr && io_sel && io_data_reg;
   assign halt_set = bus_wr && io_sel && io_stat_reg;
   assign rx_rd    = bus_rd && io_sel && io_data_reg;

   assign pop     = (count_q != '0) && tx_ready;
   assign push_ok = push_req && ((count_q != DEPTH_C) || pop);

   assign rx_pop         = rx_rd && rx_valid;
   assign tx_valid       = (count_q != '0);
   assign tx_data        = fifo_mem[rd_ptr_q];
   assign mem_din        = rd_sel_q ? ram_rd_q : io_rd_q;
   assign io_buffer_full = full_q;
   assign halt           = halt_q;
   assign overflow       = ovf_q;

   // Block RAM with registered read; old data wins on same-address access.
   always_ff @(posedge clk) begin
      if (ram_we) ram[ram_addr] <= mem_dout;
      if (ram_re) ram_rd_q <= ram[ram_addr];
   end

   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr_q] <= mem_dout;
   end

   always_comb begin
      io_rd_d  = io_rd_q;
      rd_sel_d = rd_sel_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      halt_d   = halt_q;
      ovf_d    = ovf_q;

      if (bus_rd) begin
         rd_sel_d = !io_sel;
         if (io_sel) begin
            if (io_data_reg)      io_rd_d = rx_valid ? rx_data : 8'h00;
            else if (io_stat_reg) io_rd_d = {6'b0, ovf_q, full_q};
            else                  io_rd_d = 8'h00;
         end
      end

      if (halt_set) halt_d = 1'b1;
      if (push_req && !push_ok) ovf_d = 1'b1;
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

      case ({push_ok, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      full_d = (count_d >= ALMOST_C);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io_rd_q  <= 8'h00;
         rd_sel_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         halt_q   <= 1'b0;
         ovf_q    <= 1'b0;
         full_q   <= 1'b0;
      end else begin
         io_rd_q  <= io_rd_d;
         rd_sel_q <= rd_sel_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         halt_q   <= halt_d;
         ovf_q    <= ovf_d;
         full_q   <= full_d;
      end
   end

endmodule
